// File: rtl/ffdiv_arbiter.sv
// Round-robin arbiter that time-shares one floating-point divider between NUM_REQ clients.
// Optional statistics outputs (rsp_latency, stat_ops, stat_cycles) are enabled by FFDIV_ARB_STATS_EN.
module ffdiv_arbiter #(
    parameter int  NUM_REQ       = 4,
    parameter int  OPERAND_WIDTH = 32,
    parameter int  FLAG_SIZE     = 5,
    parameter int  TIMEOUT       = 64,
    localparam int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*OPERAND_WIDTH-1:0] req_operand1,
    input  logic [NUM_REQ*OPERAND_WIDTH-1:0] req_operand2,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [ID_W-1:0]                  rsp_id,
    output logic [OPERAND_WIDTH-1:0]         rsp_result,
    output logic [FLAG_SIZE-1:0]             rsp_flag,
    output logic                             rsp_timeout,
    output logic                             busy,
    output logic                             div_en,
    output logic [OPERAND_WIDTH-1:0]         div_operand1,
    output logic [OPERAND_WIDTH-1:0]         div_operand2,
    input  logic                             div_ready,
    input  logic [OPERAND_WIDTH-1:0]         div_result,
    input  logic [FLAG_SIZE-1:0]             div_flag
`ifdef FFDIV_ARB_STATS_EN
    ,
    output logic [7:0]                       rsp_latency,
    output logic [31:0]                      stat_ops,
    output logic [31:0]                      stat_cycles
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]               r_state;
    logic                     r_armed;
    logic [ID_W-1:0]          r_last;
    logic [ID_W-1:0]          r_id;
    logic [7:0]               r_cnt;
    logic [OPERAND_WIDTH-1:0] r_op1;
    logic [OPERAND_WIDTH-1:0] r_op2;
    logic [OPERAND_WIDTH-1:0] r_result;
    logic [FLAG_SIZE-1:0]     r_flag;
    logic                     r_timeout;

    logic                     w_any_req;
    logic                     w_hi_found;
    logic [ID_W-1:0]          w_hi_idx;
    logic [ID_W-1:0]          w_lo_idx;
    logic [ID_W-1:0]          w_gnt_idx;
    logic [NUM_REQ-1:0]       w_gnt_onehot;
    logic [OPERAND_WIDTH-1:0] w_sel_op1;
    logic [OPERAND_WIDTH-1:0] w_sel_op2;
    logic                     w_grant;
    logic                     w_timeout_hit;

    // Round-robin search: lowest valid index above r_last wins, else lowest valid index overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (ID_W'(i) > r_last) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = ID_W'(i);
                end else begin
                    w_lo_idx = ID_W'(i);
                end
            end
        end
        w_gnt_idx = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    always_comb begin
        w_gnt_onehot = '0;
        w_sel_op1    = '0;
        w_sel_op2    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == w_gnt_idx) begin
                w_gnt_onehot[i] = 1'b1;
                w_sel_op1       = req_operand1[i*OPERAND_WIDTH +: OPERAND_WIDTH];
                w_sel_op2       = req_operand2[i*OPERAND_WIDTH +: OPERAND_WIDTH];
            end
        end
    end

    assign w_any_req     = |req_valid;
    // r_armed keeps grants off while reset is asserted and for the first cycle after release.
    assign w_grant       = r_armed && (r_state == S_IDLE) && w_any_req;
    assign w_timeout_hit = (r_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_armed   <= 1'b0;
            r_last    <= ID_W'(NUM_REQ - 1);
            r_id      <= '0;
            r_cnt     <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_result  <= '0;
            r_flag    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_op1   <= w_sel_op1;
                        r_op2   <= w_sel_op2;
                        r_id    <= w_gnt_idx;
                        r_last  <= w_gnt_idx;
                        r_cnt   <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (div_ready) begin
                        r_result  <= div_result;
                        r_flag    <= div_flag;
                        r_timeout <= 1'b0;
                        r_state   <= S_RESP;
                    end else if (w_timeout_hit) begin
                        r_result  <= '0;
                        r_flag    <= '0;
                        r_timeout <= 1'b1;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // A completion still held high by the divider (e.g. after a timeout) is discarded here.
                    if (!div_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready    = w_grant ? w_gnt_onehot : '0;
    assign busy         = (r_state != S_IDLE);
    assign div_en       = (r_state == S_BUSY);
    assign div_operand1 = r_op1;
    assign div_operand2 = r_op2;
    assign rsp_valid    = (r_state == S_RESP);
    assign rsp_id       = r_id;
    assign rsp_result   = r_result;
    assign rsp_flag     = r_flag;
    assign rsp_timeout  = r_timeout;

`ifdef FFDIV_ARB_STATS_EN
    logic [7:0]  r_lat;
    logic [31:0] r_ops;
    logic [31:0] r_cycles;
    logic [32:0] w_cyc_sum;
    logic        w_rsp_fire;

    assign w_rsp_fire = (r_state == S_RESP) && rsp_ready;
    assign w_cyc_sum  = {1'b0, r_cycles} + {25'd0, r_lat};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat    <= '0;
            r_ops    <= '0;
            r_cycles <= '0;
        end else begin
            // Latency counts the completing BUSY cycle, so a timeout reports exactly TIMEOUT.
            if ((r_state == S_BUSY) && (div_ready || w_timeout_hit)) begin
                r_lat <= r_cnt + 8'd1;
            end
            if (w_rsp_fire) begin
                if (r_ops != '1) begin
                    r_ops <= r_ops + 32'd1;
                end
                r_cycles <= w_cyc_sum[32] ? '1 : w_cyc_sum[31:0];
            end
        end
    end

    assign rsp_latency = r_lat;
    assign stat_ops    = r_ops;
    assign stat_cycles = r_cycles;
`endif

endmodule
